// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL / clock-domain consumers.
interface pll_reset_sequencer_if;
  logic       locked;
  logic       pll_rst;
  logic [3:0] rst_out;
  logic       ready;
  logic       lock_lost;
  logic [3:0] retry_cnt;

  modport master (
    input  locked,
    output pll_rst, rst_out, ready, lock_lost, retry_cnt
  );

  modport slave (
    output locked,
    input  pll_rst, rst_out, ready, lock_lost, retry_cnt
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor: pulses the PLL reset, waits for and debounces lock,
// then releases four domain resets in ascending order; any later lock loss restarts it.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned STAGE_GAP      = 256
) (
  input  logic                          refclk,
  input  logic                          rst,
  pll_reset_sequencer_if.master         bus
);

  // RELEASE runs the counter up to three stage gaps, so it takes part in the sizing.
  localparam int unsigned RELEASE_CYCLES = 3 * STAGE_GAP;
  localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CD  = (STABLE_CYCLES > RELEASE_CYCLES) ? STABLE_CYCLES : RELEASE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t RST_LAST     = cnt_t'(PLL_RST_CYCLES - 1);
  localparam cnt_t TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT - 1);
  localparam cnt_t STABLE_LAST  = cnt_t'(STABLE_CYCLES - 1);
  localparam cnt_t GAP1_LAST    = cnt_t'(STAGE_GAP - 1);
  localparam cnt_t GAP2_LAST    = cnt_t'(2 * STAGE_GAP - 1);
  localparam cnt_t GAP3_LAST    = cnt_t'(3 * STAGE_GAP - 1);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_DEBOUNCE,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [1:0] sync_q;
  logic       locked_s;
  logic       pll_rst_q, pll_rst_d;
  logic [3:0] rst_out_q, rst_out_d;
  logic       ready_q, ready_d;
  logic       lock_lost_q, lock_lost_d;
  logic [3:0] retry_q, retry_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the async reset branch also forces the synchronizer.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.locked};
    end
  end

  assign locked_s = sync_q[1];

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      rst_out_q   <= 4'hF;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      retry_q     <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_rst_q   <= pll_rst_d;
      rst_out_q   <= rst_out_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      retry_q     <= retry_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + cnt_t'(1);
    rst_out_d   = rst_out_q;
    ready_d     = ready_q;
    lock_lost_d = 1'b0;
    retry_d     = retry_q;

    case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end

      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_DEBOUNCE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_RESET_PLL;
          if (retry_q != 4'hF) retry_d = retry_q + 4'h1;
        end
      end

      S_DEBOUNCE: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d   = S_RELEASE;
          rst_out_d = 4'hE;
        end
      end

      // Lock loss outranks the next release step, so no bit deasserts after a drop.
      S_RELEASE: begin
        if (!locked_s) begin
          state_d     = S_RESET_PLL;
          rst_out_d   = 4'hF;
          ready_d     = 1'b0;
          lock_lost_d = 1'b1;
        end else if (cnt_q == GAP1_LAST) begin
          rst_out_d = 4'hC;
        end else if (cnt_q == GAP2_LAST) begin
          rst_out_d = 4'h8;
        end else if (cnt_q == GAP3_LAST) begin
          state_d   = S_RUN;
          rst_out_d = 4'h0;
          ready_d   = 1'b1;
        end
      end

      S_RUN: begin
        cnt_d = cnt_q;
        if (!locked_s) begin
          state_d     = S_RESET_PLL;
          rst_out_d   = 4'hF;
          ready_d     = 1'b0;
          lock_lost_d = 1'b1;
        end
      end

      default: begin
        state_d   = S_RESET_PLL;
        rst_out_d = 4'hF;
        ready_d   = 1'b0;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;
    pll_rst_d = (state_d == S_RESET_PLL);
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.rst_out   = rst_out_q;
  assign bus.ready     = ready_q;
  assign bus.lock_lost = lock_lost_q;
  assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: a per-step vector table plus hand-written
// sequences for retry saturation, async reset mid-RUN and debounce rejection.
module tb_pll_reset_sequencer;

  logic refclk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic watch_ll = 1'b0;
  logic ll_seen  = 1'b0;

  always #5 refclk = ~refclk;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .STAGE_GAP     (3)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .bus   (bus.master)
  );

  typedef struct {
    logic       locked;
    int         cycles;
    logic       pll_rst;
    logic [3:0] rst_out;
    logic       ready;
    logic       lock_lost;
    logic [3:0] retry;
  } vec_t;

  vec_t vecs [30];

  always @(negedge refclk) if (watch_ll && bus.lock_lost) ll_seen = 1'b1;

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_outs(input string tag, input logic p, input logic [3:0] r,
                            input logic rd, input logic ll, input logic [3:0] rc);
    check({tag, " pll_rst"},   32'(bus.pll_rst),   32'(p));
    check({tag, " rst_out"},   32'(bus.rst_out),   32'(r));
    check({tag, " ready"},     32'(bus.ready),     32'(rd));
    check({tag, " lock_lost"}, 32'(bus.lock_lost), 32'(ll));
    check({tag, " retry_cnt"}, 32'(bus.retry_cnt), 32'(rc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Edge numbers below count refclk edges after rst release.
    vecs[0]  = '{1'b0,  1, 1'b1, 4'hF, 1'b0, 1'b0, 4'd0}; // E1
    vecs[1]  = '{1'b0,  2, 1'b1, 4'hF, 1'b0, 1'b0, 4'd0}; // E3 last RESET_PLL cycle
    vecs[2]  = '{1'b0,  1, 1'b0, 4'hF, 1'b0, 1'b0, 4'd0}; // E4 WAIT_LOCK
    vecs[3]  = '{1'b0,  2, 1'b0, 4'hF, 1'b0, 1'b0, 4'd0}; // E6 locked rises
    vecs[4]  = '{1'b1, 10, 1'b0, 4'hF, 1'b0, 1'b0, 4'd0}; // E16 last DEBOUNCE cycle
    vecs[5]  = '{1'b1,  1, 1'b0, 4'hE, 1'b0, 1'b0, 4'd0}; // E17
    vecs[6]  = '{1'b1,  2, 1'b0, 4'hE, 1'b0, 1'b0, 4'd0};
    vecs[7]  = '{1'b1,  1, 1'b0, 4'hC, 1'b0, 1'b0, 4'd0}; // E20
    vecs[8]  = '{1'b1,  2, 1'b0, 4'hC, 1'b0, 1'b0, 4'd0};
    vecs[9]  = '{1'b1,  1, 1'b0, 4'h8, 1'b0, 1'b0, 4'd0}; // E23
    vecs[10] = '{1'b1,  2, 1'b0, 4'h8, 1'b0, 1'b0, 4'd0};
    vecs[11] = '{1'b1,  1, 1'b0, 4'h0, 1'b1, 1'b0, 4'd0}; // E26 RUN
    vecs[12] = '{1'b1,  5, 1'b0, 4'h0, 1'b1, 1'b0, 4'd0}; // E31
    vecs[13] = '{1'b0,  2, 1'b0, 4'h0, 1'b1, 1'b0, 4'd0}; // E33 drop still in sync
    vecs[14] = '{1'b1,  1, 1'b1, 4'hF, 1'b0, 1'b1, 4'd0}; // E34 loss reaches outputs
    vecs[15] = '{1'b1,  1, 1'b1, 4'hF, 1'b0, 1'b0, 4'd0};
    vecs[16] = '{1'b1,  2, 1'b1, 4'hF, 1'b0, 1'b0, 4'd0}; // E37
    vecs[17] = '{1'b1,  1, 1'b0, 4'hF, 1'b0, 1'b0, 4'd0}; // E38 WAIT_LOCK
    vecs[18] = '{1'b1,  9, 1'b0, 4'hE, 1'b0, 1'b0, 4'd0}; // E47 RELEASE again
    vecs[19] = '{1'b1,  3, 1'b0, 4'hC, 1'b0, 1'b0, 4'd0}; // E50
    vecs[20] = '{1'b0,  2, 1'b0, 4'hC, 1'b0, 1'b0, 4'd0}; // E52
    vecs[21] = '{1'b0,  1, 1'b1, 4'hF, 1'b0, 1'b1, 4'd0}; // E53 no step to 8
    vecs[22] = '{1'b0,  1, 1'b1, 4'hF, 1'b0, 1'b0, 4'd0};
    vecs[23] = '{1'b0,  2, 1'b1, 4'hF, 1'b0, 1'b0, 4'd0}; // E56
    vecs[24] = '{1'b0,  1, 1'b0, 4'hF, 1'b0, 1'b0, 4'd0}; // E57
    vecs[25] = '{1'b0, 19, 1'b0, 4'hF, 1'b0, 1'b0, 4'd0}; // E76 last WAIT cycle
    vecs[26] = '{1'b0,  1, 1'b1, 4'hF, 1'b0, 1'b0, 4'd1}; // E77 retry
    vecs[27] = '{1'b0,  3, 1'b1, 4'hF, 1'b0, 1'b0, 4'd1};
    vecs[28] = '{1'b0,  1, 1'b0, 4'hF, 1'b0, 1'b0, 4'd1};
    vecs[29] = '{1'b0, 20, 1'b1, 4'hF, 1'b0, 1'b0, 4'd2}; // E101

    rst        = 1'b1;
    bus.locked = 1'b0;
    step(3);
    check_outs("reset", 1'b1, 4'hF, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;

    for (int i = 0; i < 30; i++) begin
      bus.locked = vecs[i].locked;
      step(vecs[i].cycles);
      check_outs($sformatf("vec%0d", i), vecs[i].pll_rst, vecs[i].rst_out,
                 vecs[i].ready, vecs[i].lock_lost, vecs[i].retry);
    end

    // Retry every 24 cycles, saturating at 15.
    for (int n = 3; n <= 17; n++) begin
      step(24);
      check($sformatf("sat%0d retry_cnt", n), 32'(bus.retry_cnt), (n > 15) ? 32'd15 : 32'(n));
      check($sformatf("sat%0d pll_rst", n), 32'(bus.pll_rst), 32'd1);
    end
    check("sat rst_out", 32'(bus.rst_out), 32'hF);

    begin
      logic found;
      found      = 1'b0;
      bus.locked = 1'b1;
      for (int k = 0; k < 60 && !found; k++) begin
        step(1);
        if (bus.ready) found = 1'b1;
      end
      check("reach run", 32'(found), 32'd1);
      check("run retry_cnt", 32'(bus.retry_cnt), 32'd15);
      check("run rst_out", 32'(bus.rst_out), 32'h0);
    end

    // Async reset pulse entirely between two edges.
    #2;
    rst = 1'b1;
    #1;
    check_outs("async", 1'b1, 4'hF, 1'b0, 1'b0, 4'd0);
    bus.locked = 1'b0;
    #1;
    rst = 1'b0;
    step(1);
    check_outs("post_rst", 1'b1, 4'hF, 1'b0, 1'b0, 4'd0);

    // Debounce reject: 5 high, 2 low, then high again.
    step(3);
    watch_ll   = 1'b1;
    bus.locked = 1'b1;
    step(5);
    bus.locked = 1'b0;
    step(2);
    bus.locked = 1'b1;
    step(4);
    check("deb first_try rst_out", 32'(bus.rst_out), 32'hF);
    step(6);
    check("deb restart rst_out", 32'(bus.rst_out), 32'hF);
    step(1);
    check("deb release rst_out", 32'(bus.rst_out), 32'hE);
    watch_ll = 1'b0;
    check("deb lock_lost_seen", 32'(ll_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
